machine_timer: RTL and testbench

- Memory-mapped RISC-V machine timer (mtime/mtimecmp), CLINT-style.
- Sits directly upstream of the interrupt/CSR block and drives its `time_interupt` input.
- Accessed by the memory stage over a simple 32-bit single-cycle-request bus.
- Interrupt level is registered, level-sensitive, and cleared only by software rewriting mtimecmp (or mtime).

---
 rtl/machine_timer_pkg.sv | 13 +
 rtl/machine_timer_if.sv | 14 +
 rtl/machine_timer_prescaler.sv | 32 +++
 rtl/machine_timer.sv | 96 +++++++++
 tb/tb_machine_timer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/machine_timer_pkg.sv
// Shared types and register offsets for the machine timer (mtime/mtimecmp).
// Optional prescaler is enabled by defining MTIMER_PRESCALE_EN.
package timer_pkg;

    typedef logic [63:0] mtime_t;

    localparam logic [4:0] MTIME_LO    = 5'h00;
    localparam logic [4:0] MTIME_HI    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] PRESCALE    = 5'h10;

endpackage

// File: rtl/machine_timer_if.sv
// Single-cycle-request 32-bit bus between the memory stage and the machine timer.
interface machine_timer_if;

    logic        sel;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output sel, we, addr, wdata, input  rdata, ack);
    modport slave  (input  sel, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/machine_timer_prescaler.sv
// Tick generator for mtime: one tick every (prescale+1) cycles.
// Only instantiated when MTIMER_PRESCALE_EN is defined.
module timer_prescaler #(
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] count;

    assign tick = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= PRESCALE_RST;
            count    <= '0;
        end else if (load) begin
            prescale <= load_val;
            count    <= load_val;
        end else if (tick) begin
            count    <= prescale;
        end else begin
            count    <= count - 16'd1;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// CLINT-style RISC-V machine timer: 64-bit mtime/mtimecmp with a registered
// level interrupt. Define MTIMER_PRESCALE_EN to add the prescale register at 0x10.
module machine_timer
    import timer_pkg::*;
#(
    parameter mtime_t RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
`ifdef MTIMER_PRESCALE_EN
    ,
    parameter logic [15:0] PRESCALE_RST = 16'd0
`endif
) (
    input  logic            clk,
    input  logic            rst,
    machine_timer_if.slave  bus,
    output logic            time_interupt
);

    logic [31:0] mtime_lo, mtime_hi;
    logic [31:0] cmp_lo, cmp_hi;
    logic [31:0] lo_nxt, hi_nxt;
    logic [32:0] lo_inc;
    logic [31:0] rd_mux;
    logic [4:0]  word_addr;
    logic        wr;
    logic        tick;

    assign word_addr = bus.addr & 5'b11100;
    assign wr        = bus.sel & bus.we;

`ifdef MTIMER_PRESCALE_EN
    logic [15:0] prescale;

    timer_prescaler #(
        .PRESCALE_RST (PRESCALE_RST)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .load     (wr && (word_addr == PRESCALE)),
        .load_val (bus.wdata[15:0]),
        .prescale (prescale),
        .tick     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // A low-half write both replaces the low word and swallows its carry;
    // a high-half write keeps the low word counting.
    always_comb begin
        lo_inc = {1'b0, mtime_lo} + {32'd0, tick};
        lo_nxt = lo_inc[31:0];
        hi_nxt = mtime_hi + {31'd0, lo_inc[32]};
        if (wr && (word_addr == MTIME_LO)) begin
            lo_nxt = bus.wdata;
            hi_nxt = mtime_hi;
        end
        if (wr && (word_addr == MTIME_HI)) begin
            hi_nxt = bus.wdata;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word_addr)
            MTIME_LO:    rd_mux = mtime_lo;
            MTIME_HI:    rd_mux = mtime_hi;
            MTIMECMP_LO: rd_mux = cmp_lo;
            MTIMECMP_HI: rd_mux = cmp_hi;
`ifdef MTIMER_PRESCALE_EN
            PRESCALE:    rd_mux = {16'd0, prescale};
`endif
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_lo      <= '0;
            mtime_hi      <= '0;
            cmp_lo        <= RESET_CMP[31:0];
            cmp_hi        <= RESET_CMP[63:32];
            bus.ack       <= 1'b0;
            bus.rdata     <= '0;
            time_interupt <= 1'b0;
        end else begin
            mtime_lo      <= lo_nxt;
            mtime_hi      <= hi_nxt;
            if (wr && (word_addr == MTIMECMP_LO)) cmp_lo <= bus.wdata;
            if (wr && (word_addr == MTIMECMP_HI)) cmp_hi <= bus.wdata;
            bus.ack       <= bus.sel;
            bus.rdata     <= bus.sel ? rd_mux : '0;
            time_interupt <= ({mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo});
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Scoreboard bench for machine_timer: a 64-bit arithmetic reference model
// predicts every read, ack and interrupt level; a negedge monitor compares.
module tb_machine_timer;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic irq;

    always #5 clk = ~clk;

    machine_timer_if bus_if ();

    machine_timer #(
        .RESET_CMP (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_if),
        .time_interupt (irq)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] exp_q[$];
    mtime_t      m_time  = '0;
    mtime_t      m_cmp   = '1;
    logic        exp_ack = 1'b0;
    logic        exp_irq = 1'b0;
    logic        m_tick;
    logic [4:0]  m_wa;
    logic        m_wr;
`ifdef MTIMER_PRESCALE_EN
    logic [15:0] m_ps  = '0;
    logic [15:0] m_cnt = '0;
`endif

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            MTIME_LO:    return m_time[31:0];
            MTIME_HI:    return m_time[63:32];
            MTIMECMP_LO: return m_cmp[31:0];
            MTIMECMP_HI: return m_cmp[63:32];
`ifdef MTIMER_PRESCALE_EN
            PRESCALE:    return {16'd0, m_ps};
`endif
            default:     return 32'd0;
        endcase
    endfunction

    // Reference model: advances once per clock from the sampled bus inputs.
    always @(posedge clk) begin
        if (rst) begin
            m_time  = '0;
            m_cmp   = '1;
            exp_ack = 1'b0;
            exp_irq = 1'b0;
`ifdef MTIMER_PRESCALE_EN
            m_ps  = '0;
            m_cnt = '0;
`endif
        end else begin
`ifdef MTIMER_PRESCALE_EN
            m_tick = (m_cnt == 16'd0);
`else
            m_tick = 1'b1;
`endif
            m_wa = bus_if.addr & 5'b11100;
            m_wr = bus_if.sel && bus_if.we;
            if (bus_if.sel) exp_q.push_back(model_read(m_wa));
            exp_ack = bus_if.sel;
            exp_irq = (m_time >= m_cmp);
            if (m_wr && m_wa == MTIME_LO)
                m_time = {m_time[63:32], bus_if.wdata};
            else if (m_wr && m_wa == MTIME_HI)
                m_time = {bus_if.wdata, m_time[31:0] + 32'(m_tick)};
            else
                m_time = m_time + 64'(m_tick);
            if (m_wr && m_wa == MTIMECMP_LO) m_cmp[31:0]  = bus_if.wdata;
            if (m_wr && m_wa == MTIMECMP_HI) m_cmp[63:32] = bus_if.wdata;
`ifdef MTIMER_PRESCALE_EN
            if (m_wr && m_wa == PRESCALE) begin
                m_ps  = bus_if.wdata[15:0];
                m_cnt = bus_if.wdata[15:0];
            end else if (m_tick) begin
                m_cnt = m_ps;
            end else begin
                m_cnt = m_cnt - 16'd1;
            end
`endif
        end
    end

    // Monitor: pops one expectation per predicted ack.
    always @(negedge clk) begin
        logic [31:0] e;
        n_cmp++;
        if (bus_if.ack !== exp_ack) begin
            n_bad++;
            $display("FAIL ack t=%0t got=%b exp=%b", $time, bus_if.ack, exp_ack);
        end
        n_cmp++;
        if (irq !== exp_irq) begin
            n_bad++;
            $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, exp_irq);
        end
        if (exp_ack) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd0;
            n_cmp++;
            if (bus_if.rdata !== e) begin
                n_bad++;
                $display("FAIL rdata t=%0t got=%h exp=%h", $time, bus_if.rdata, e);
            end
        end else begin
            n_cmp++;
            if (bus_if.rdata !== 32'd0) begin
                n_bad++;
                $display("FAIL rdata_idle t=%0t got=%h exp=0", $time, bus_if.rdata);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            bus_if.sel = 1'b0;
            bus_if.we  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        bus_if.sel = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.wdata = d;
        @(negedge clk);
        bus_if.sel = 1'b0; bus_if.we = 1'b0;
    endtask

    task automatic bus_rd(input logic [4:0] a);
        bus_if.sel = 1'b1; bus_if.we = 1'b0; bus_if.addr = a; bus_if.wdata = $urandom;
        @(negedge clk);
        bus_if.sel = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t run did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  a;
        logic [31:0] d;
        int unsigned r;
        rst = 1'b1;
        bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
        do_reset(3);

        idle(10);
        bus_rd(MTIME_LO);
        bus_rd(MTIMECMP_HI);
        bus_rd(MTIMECMP_LO);
        idle(2);

        do_reset(2);
        bus_wr(MTIMECMP_LO, 32'd20);
        bus_wr(MTIMECMP_HI, 32'd0);
        idle(25);
        bus_wr(MTIMECMP_HI, 32'hFFFF_FFFF);
        idle(4);

        bus_wr(MTIME_LO, 32'hFFFF_FFFE);
        bus_wr(MTIME_HI, 32'd0);
        idle(1);
        bus_rd(MTIME_HI);
        bus_rd(MTIME_LO);

        bus_wr(MTIME_LO, 32'hFFFF_FFFF);
        bus_wr(MTIME_LO, 32'd5);
        bus_rd(MTIME_LO);
        bus_rd(MTIME_HI);

        bus_wr(MTIMECMP_HI, 32'd0);
        bus_wr(MTIMECMP_LO, 32'd100);
        bus_wr(MTIME_HI, 32'hFFFF_FFFF);
        bus_wr(MTIME_LO, 32'hFFFF_FFFC);
        idle(8);
        bus_rd(MTIME_HI);

        bus_if.sel = 1'b1; bus_if.we = 1'b0; bus_if.addr = MTIME_LO;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus_if.sel = 1'b0;
        idle(1);
        bus_rd(MTIMECMP_LO);
        bus_rd(MTIMECMP_HI);
        bus_rd(5'h14);
        bus_wr(5'h14, 32'hDEAD_BEEF);
        bus_rd(5'h17);

`ifdef MTIMER_PRESCALE_EN
        bus_wr(PRESCALE, 32'd3);
        idle(13);
        bus_rd(MTIME_LO);
        bus_rd(PRESCALE);
        bus_wr(PRESCALE, 32'd0);
`endif
        bus_rd(PRESCALE);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            a = 5'($urandom_range(0, 7) << 2) | 5'($urandom_range(0, 3));
            d = ((a & 5'b11100) == PRESCALE) ? 32'($urandom_range(0, 4)) : $urandom;
            if (r < 30)       idle(1);
            else if (r < 65)  bus_rd(a);
            else if (r < 98)  bus_wr(a, d);
            else              do_reset(1);
        end

        idle(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain got=%0d left exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
